frame_fifo_pixel_reader: RTL and testbench
==========================================

# frame_fifo_pixel_reader

Read-side drain engine for the frame FIFO in the display path. It pops 32-bit words from the FIFO read port, accounts for the FIFO's read latency and splits each word into two 16-bit RGB565 pixels. It presents the pixels on a valid/ready stream with start-of-frame and end-of-line markers, and counts pixels and lines so that exactly one frame is emitted per arm pulse. It sits in the `rd_clk` domain between the frame FIFO and the video timing/scan-out logic.

## Interface
Parameters:
- `c_H_PIXELS`, 640, pixels per line; must be even, range 2..4094.
- `c_V_LINES`, 480, lines per frame; range 1..4095.
- `c_FIFO_RD_LAT`, 1, FIFO read latency in cycles; legal values 1 or 2, matching the FIFO's output register setting.

Ports:
- `rd_clk`, in, 1, the single clock.
- `rd_rst`, in, 1, reset; asynchronous and active-high.
- `frame_start`, in, 1, single-cycle pulse that arms one frame.
- `fifo_rd_data`, in, 32, FIFO read data.
- `fifo_rd_empty`, in, 1, FIFO empty flag.
- `fifo_rd_en`, out, 1, FIFO pop request.
- `pix_data`, out, 16, pixel value.
- `pix_valid`, out, 1, pixel valid.
- `pix_ready`, in, 1, sink accepts the pixel.
- `pix_sof`, out, 1, marks the first pixel of the frame; qualified by `pix_valid`.
- `pix_eol`, out, 1, marks the last pixel of each line; qualified by `pix_valid`.
- `busy`, out, 1, high while a frame is in progress.
- `underflow`, out, 1, sticky error flag.

## Operation
- State machine with two states:
  - IDLE: on `frame_start` go to ACTIVE and clear the counters and `underflow`.
  - ACTIVE: when the last pixel is accepted (h_cnt = c_H_PIXELS-1, v_cnt = c_V_LINES-1, `pix_valid` and `pix_ready`), return to IDLE.
  - A `frame_start` seen while in ACTIVE is ignored.
- Storage:
  - One word register with flag `word_vld`, half selector `half` (0 = bits [15:0], 1 = bits [31:16]).
  - A latency shift register of depth `c_FIFO_RD_LAT` that tracks the one outstanding pop (`inflight`).
- Pop rule: assert `fifo_rd_en` in ACTIVE when `!fifo_rd_empty`, `!inflight`, words still owed for the frame > 0, and one of the following holds:
  - `!word_vld`, or
  - `half`=1 and the current pixel is being accepted.
- Words owed: c_H_PIXELS*c_V_LINES/2 words per frame. A counter tracks pops, so the block never pops past the end of the frame.
- Data return: `c_FIFO_RD_LAT` cycles after a pop, `fifo_rd_data` loads into the word register, `word_vld` is set and `half` is cleared.
- Acceptance:
  - `pix_valid` = ACTIVE & `word_vld`.
  - `pix_data` = `half` ? word[31:16] : word[15:0].
  - On `pix_valid` & `pix_ready`: if `half`=0, set `half`; else clear `word_vld`, unless a new word lands in that same cycle.
- Counters: h_cnt wraps at c_H_PIXELS-1 and v_cnt increments on the wrap. `pix_sof` = (h_cnt=0 & v_cnt=0); `pix_eol` = (h_cnt=c_H_PIXELS-1).
- Underflow: in ACTIVE, `pix_ready`=1 with `pix_valid`=0 sets `underflow` (sticky). It clears only on an accepted `frame_start` or on reset. The stream stalls; no data is dropped or invented.
- Backpressure: with `pix_ready`=0, all outputs hold and no further pop is issued beyond the one already in flight.

## Timing
- Reset values: state IDLE; `fifo_rd_en`, `pix_valid`, `pix_sof`, `pix_eol`, `busy`, `underflow` all 0; `pix_data` 0; all counters, `word_vld`, `half`, `inflight` cleared.
- `frame_start` at cycle 0 gives `busy`=1 at cycle 1. The first `fifo_rd_en` can assert at cycle 1, and the first `pix_valid` at cycle 1+`c_FIFO_RD_LAT`.
- Sustained throughput: 1 pixel/cycle with `c_FIFO_RD_LAT`=1. With latency 2, one bubble every 2 pixels.
- `busy` falls in the cycle after the last pixel is accepted.
- Reset mid-frame: the in-flight word and any buffered pixels are discarded. The FIFO must be reset alongside this block.

## Configuration
- `FRAME_RD_UFL_CNT_EN` defined:
  - Adds output `ufl_cnt` [15:0], which counts cycles meeting the underflow condition.
  - It saturates at 16'hFFFF and clears on an accepted `frame_start` and on reset.
- Not defined: the port and the counter are absent; the sticky `underflow` flag is still present.

## Test plan
All scenarios use c_H_PIXELS=4, c_V_LINES=2 unless stated.
- Reset with all inputs idle: every output is 0, and `fifo_rd_en` stays 0 even with `fifo_rd_empty`=0.
- FIFO preloaded with words 0x00020001, 0x00040003, 0x00060005, 0x00080007; `pix_ready`=1; pulse `frame_start`:
  - Pixels emitted in order 1..8.
  - `pix_sof` on pixel 1; `pix_eol` on pixels 4 and 8.
  - Exactly 4 pops; `busy` low after pixel 8.
- Same data, `pix_ready` toggled 1010…: order unchanged, no pixel duplicated, and `fifo_rd_en` never asserts with `inflight`=1.
- FIFO empty after 1 word, sink ready:
  - `underflow`=1 from the third pixel slot onward.
  - Refilling resumes the output with pixel 3.
  - With `FRAME_RD_UFL_CNT_EN` defined, `ufl_cnt` equals the number of stalled cycles.
- `frame_start` pulsed mid-frame: ignored, and the counts complete normally. A second pulse after `busy` falls streams a second frame with `pix_sof` set again.
- `c_FIFO_RD_LAT`=2, assert `rd_rst` after pixel 3: all outputs are 0 next cycle; a new frame after reset starts cleanly from `pix_sof`.

Source files
------------

// File: rtl/frame_fifo_pixel_reader.sv
// Frame FIFO drain engine: pops 32-bit words, splits them into RGB565 pixels and emits one frame per arm pulse.
// Optional FRAME_RD_UFL_CNT_EN adds the ufl_cnt stalled-cycle counter output.
module frame_fifo_pixel_reader #(
  parameter int c_H_PIXELS    = 640,
  parameter int c_V_LINES     = 480,
  parameter int c_FIFO_RD_LAT = 1
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        frame_start,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  output logic        fifo_rd_en,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy,
  output logic        underflow
`ifdef FRAME_RD_UFL_CNT_EN
  ,
  output logic [15:0] ufl_cnt
`endif
);

  localparam int c_WORDS = (c_H_PIXELS * c_V_LINES) / 2;
  localparam int c_WW    = $clog2(c_WORDS + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t          state_q;
  logic [31:0]     word_q;
  logic            word_vld_q;
  logic            half_q;
  logic [11:0]     h_cnt_q, h_cnt_d;
  logic [11:0]     v_cnt_q, v_cnt_d;
  logic [c_WW-1:0] words_left_q;
  logic            underflow_q;
  logic            active, accept, h_last, v_last, ufl_cond;
  logic            land, inflight;
`ifdef FRAME_RD_UFL_CNT_EN
  logic [15:0]     ufl_cnt_q;
  assign ufl_cnt = ufl_cnt_q;
`endif

  assign active    = (state_q == ST_ACTIVE);
  assign pix_valid = active & word_vld_q;
  assign accept    = pix_valid & pix_ready;
  assign h_last    = (h_cnt_q == 12'(c_H_PIXELS - 1));
  assign v_last    = (v_cnt_q == 12'(c_V_LINES - 1));
  assign ufl_cond  = active & pix_ready & ~word_vld_q;

  // A refill may be requested in the same cycle the upper half of the current word leaves.
  assign fifo_rd_en = active & ~fifo_rd_empty & ~inflight & (words_left_q != '0) &
                      (~word_vld_q | (half_q & accept));

  assign pix_data  = half_q ? word_q[31:16] : word_q[15:0];
  assign pix_sof   = pix_valid & (h_cnt_q == 12'd0) & (v_cnt_q == 12'd0);
  assign pix_eol   = pix_valid & h_last;
  assign busy      = active;
  assign underflow = underflow_q;

  // Read data is sampled c_FIFO_RD_LAT-1 edges after the pop edge (show-ahead data at latency 1).
  generate
    if (c_FIFO_RD_LAT == 1) begin : g_lat1
      assign land     = fifo_rd_en;
      assign inflight = 1'b0;
    end else begin : g_lat2
      logic pend_q;
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) pend_q <= 1'b0;
        else        pend_q <= fifo_rd_en;
      end
      assign land     = pend_q;
      assign inflight = pend_q;
    end
  endgenerate

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (accept) begin
      if (h_last) begin
        h_cnt_d = 12'd0;
        v_cnt_d = v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= ST_IDLE;
      word_q       <= 32'd0;
      word_vld_q   <= 1'b0;
      half_q       <= 1'b0;
      h_cnt_q      <= 12'd0;
      v_cnt_q      <= 12'd0;
      words_left_q <= '0;
      underflow_q  <= 1'b0;
`ifdef FRAME_RD_UFL_CNT_EN
      ufl_cnt_q    <= 16'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q      <= ST_ACTIVE;
            h_cnt_q      <= 12'd0;
            v_cnt_q      <= 12'd0;
            words_left_q <= c_WW'(c_WORDS);
            underflow_q  <= 1'b0;
            word_vld_q   <= 1'b0;
            half_q       <= 1'b0;
`ifdef FRAME_RD_UFL_CNT_EN
            ufl_cnt_q    <= 16'd0;
`endif
          end
        end
        ST_ACTIVE: begin
          h_cnt_q <= h_cnt_d;
          v_cnt_q <= v_cnt_d;
          if (fifo_rd_en) words_left_q <= words_left_q - c_WW'(1);
          if (land) begin
            word_q     <= fifo_rd_data;
            word_vld_q <= 1'b1;
            half_q     <= 1'b0;
          end else if (accept) begin
            if (!half_q) half_q     <= 1'b1;
            else         word_vld_q <= 1'b0;
          end
          if (ufl_cond) underflow_q <= 1'b1;
`ifdef FRAME_RD_UFL_CNT_EN
          if (ufl_cond && (ufl_cnt_q != 16'hFFFF)) ufl_cnt_q <= ufl_cnt_q + 16'd1;
`endif
          if (accept && h_last && v_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fifo_pixel_reader.sv
// Bench for frame_fifo_pixel_reader: one lane per FIFO read latency (1 and 2), each with a FIFO model and a pixel scoreboard.
module tb_frame_fifo_pixel_reader;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int NPIX  = H * V;
  localparam int NWORD = NPIX / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d): got 0x%0h, expected 0x%0h", name, lat, act, exp);
    end
  endtask

  // ready_mode: 0 always ready, 1 toggling 1010..., 2 random
  // refill_at: >=0 push the remaining words at that relative cycle, -2 random trickle
  typedef struct {
    int preload;
    int ready_mode;
    int refill_at;
    int mid_start_at;
    bit rnd_data;
    bit timing;
    int exp_pops;
    int exp_pix;
  } vec_t;

  vec_t tbl[6];
  initial begin
    tbl[0] = '{4, 0,  0, -1, 1'b0, 1'b1, NWORD, NPIX};
    tbl[1] = '{4, 1,  0, -1, 1'b0, 1'b0, NWORD, NPIX};
    tbl[2] = '{1, 0,  6, -1, 1'b0, 1'b0, NWORD, NPIX};
    tbl[3] = '{4, 0,  0,  3, 1'b0, 1'b0, NWORD, NPIX};
    tbl[4] = '{4, 2,  0, -1, 1'b1, 1'b0, NWORD, NPIX};
    tbl[5] = '{0, 2, -2, -1, 1'b1, 1'b0, NWORD, NPIX};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int LAT = gi + 1;

    logic        rst, frame_start, fifo_rd_empty, fifo_rd_en;
    logic        pix_valid, pix_ready, pix_sof, pix_eol, busy, underflow;
    logic [31:0] fifo_rd_data;
    logic [15:0] pix_data;
`ifdef FRAME_RD_UFL_CNT_EN
    logic [15:0] ufl_cnt;
`endif

    frame_fifo_pixel_reader #(
      .c_H_PIXELS(H), .c_V_LINES(V), .c_FIFO_RD_LAT(LAT)
    ) dut (
      .rd_clk(clk), .rd_rst(rst), .frame_start(frame_start),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .underflow(underflow)
`ifdef FRAME_RD_UFL_CNT_EN
      , .ufl_cnt(ufl_cnt)
`endif
    );

    logic [31:0] fq[$];
    logic [31:0] out_reg;
    logic [15:0] exp_pix[$];
    int          acc_cyc[$];
    int          pix_idx, pops, cyc, start_cyc, exp_busy, exp_ufl, ufl_cycles, frames;
    bit          prev_en, prev_stall, prev_sof, prev_eol, first_en;
    logic [15:0] prev_data;
    bit          lane_done = 1'b0;

    task automatic fifo_refresh();
      fifo_rd_empty = (fq.size() == 0);
      if (LAT == 1) fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'h0;
      else          fifo_rd_data = out_reg;
    endtask

    task automatic push(input logic [31:0] w);
      fq.push_back(w);
      exp_pix.push_back(w[15:0]);
      exp_pix.push_back(w[31:16]);
      fifo_refresh();
    endtask

    // One clock: check outputs at the negedge, advance the reference, then apply the FIFO pop after the posedge.
    task automatic step();
      bit          pop_now;
      logic [15:0] e;
      @(negedge clk);
      pop_now = 1'b0;
      if (rst) begin
        chk("reset_outputs", LAT, {10'd0, fifo_rd_en, pix_valid, pix_sof, pix_eol, busy, underflow, pix_data}, 32'd0);
`ifdef FRAME_RD_UFL_CNT_EN
        chk("reset_ufl_cnt", LAT, {16'd0, ufl_cnt}, 32'd0);
`endif
        exp_busy = 0; exp_ufl = 0; ufl_cycles = 0; pix_idx = 0; pops = 0;
        fq.delete(); exp_pix.delete(); out_reg = 32'd0;
        prev_en = 1'b0; prev_stall = 1'b0;
      end else begin
        chk("busy", LAT, busy, exp_busy);
        chk("underflow", LAT, underflow, exp_ufl);
`ifdef FRAME_RD_UFL_CNT_EN
        chk("ufl_cnt", LAT, {16'd0, ufl_cnt}, ufl_cycles);
`endif
        if (cyc == start_cyc + 1) first_en = fifo_rd_en;
        if (exp_busy == 0) begin
          chk("idle_no_pop", LAT, fifo_rd_en, 1'b0);
        end else if (fifo_rd_en) begin
          chk("pop_allowed", LAT, {!fifo_rd_empty, pops < NWORD, !(LAT == 2 && prev_en)}, 3'b111);
        end
        if (fifo_rd_en) begin
          pop_now = 1'b1;
          pops++;
        end
        if (prev_stall)
          chk("hold", LAT, {pix_valid, pix_sof, pix_eol, pix_data}, {1'b1, prev_sof, prev_eol, prev_data});
        if (pix_valid && pix_ready) begin
          e = (exp_pix.size() > 0) ? exp_pix.pop_front() : 16'hDEAD;
          chk("pix_data", LAT, pix_data, e);
          chk("pix_sof", LAT, pix_sof, pix_idx == 0);
          chk("pix_eol", LAT, pix_eol, (pix_idx % H) == H - 1);
          acc_cyc.push_back(cyc);
          pix_idx++;
        end
        prev_stall = pix_valid && !pix_ready;
        prev_sof   = pix_sof;
        prev_eol   = pix_eol;
        prev_data  = pix_data;
        prev_en    = fifo_rd_en;
        if (exp_busy != 0 && pix_ready && !pix_valid) begin
          exp_ufl = 1;
          if (ufl_cycles < 65535) ufl_cycles++;
        end
        if (exp_busy != 0 && pix_valid && pix_ready && pix_idx == NPIX) begin
          exp_busy = 0;
        end else if (exp_busy == 0 && frame_start) begin
          exp_busy = 1; exp_ufl = 0; ufl_cycles = 0; pix_idx = 0; pops = 0;
          start_cyc = cyc;
          acc_cyc.delete();
        end
      end
      cyc++;
      @(posedge clk);
      #1;
      if (pop_now && fq.size() > 0) begin
        if (LAT == 2) out_reg = fq.pop_front();
        else          void'(fq.pop_front());
      end
      fifo_refresh();
    endtask

    task automatic run_frame(input vec_t v, input int id);
      logic [31:0] words[NWORD];
      int          nxt, rel;
      for (int k = 0; k < NWORD; k++)
        words[k] = v.rnd_data ? $urandom : {16'(2 * k + 2), 16'(2 * k + 1)};
      for (int k = 0; k < v.preload; k++) push(words[k]);
      nxt = v.preload;
      frame_start = 1'b1;
      pix_ready = (v.ready_mode == 0);
      step();
      frame_start = 1'b0;
      rel = 1;
      while (exp_busy != 0 && rel < 300) begin
        case (v.ready_mode)
          0:       pix_ready = 1'b1;
          1:       pix_ready = rel[0];
          default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        frame_start = (rel == v.mid_start_at);
        if (v.refill_at >= 0 && rel >= v.refill_at) begin
          while (nxt < NWORD) begin
            push(words[nxt]);
            nxt++;
          end
        end else if (v.refill_at == -2 && nxt < NWORD && $urandom_range(0, 2) == 0) begin
          push(words[nxt]);
          nxt++;
        end
        step();
        rel++;
      end
      frame_start = 1'b0;
      chk("frame_done", LAT, exp_busy, 0);
      chk("pixel_count", LAT, pix_idx, v.exp_pix);
      chk("pop_count", LAT, pops, v.exp_pops);
      if (v.timing) begin
        chk("first_pop_cycle", LAT, first_en, 1'b1);
        for (int k = 0; k < acc_cyc.size(); k++)
          chk("pix_cycle", LAT, acc_cyc[k] - start_cyc, 1 + LAT + k + (LAT - 1) * (k / 2));
      end
      step();
      step();
      chk("fifo_drained", LAT, fq.size(), 0);
      frames++;
      $display("lat=%0d frame %0d (row %0d): %0d pixels, %0d pops, underflow=%0d, %0d stalled cycles",
               LAT, frames, id, pix_idx, pops, exp_ufl, ufl_cycles);
    endtask

    initial begin
      rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b0; out_reg = 32'd0;
      cyc = 0; start_cyc = -10; frames = 0; exp_busy = 0; exp_ufl = 0; ufl_cycles = 0;
      pix_idx = 0; pops = 0; first_en = 1'b0; prev_data = 16'd0;
      prev_en = 1'b0; prev_stall = 1'b0; prev_sof = 1'b0; prev_eol = 1'b0;
      fifo_refresh();
      step();
      step();
      rst = 1'b0;
      // Idle with data waiting: no pop may be issued without an arm pulse.
      for (int k = 0; k < NWORD; k++) push(32'hA5A50000 + k);
      pix_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      for (int r = 0; r < 6; r++) run_frame(tbl[r], r);
      for (int i = 0; i < 6; i++) run_frame(tbl[4 + (i % 2)], 4 + (i % 2));

      // Reset in the middle of a frame, then a clean frame from start of frame.
      for (int k = 0; k < NWORD; k++) push({16'(2 * k + 2), 16'(2 * k + 1)});
      frame_start = 1'b1;
      pix_ready = 1'b1;
      step();
      frame_start = 1'b0;
      for (int k = 0; k < 50 && pix_idx < 3; k++) step();
      chk("pixels_before_reset", LAT, pix_idx, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      run_frame(tbl[0], 0);

      lane_done = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_lane[0].lane_done && g_lane[1].lane_done);
      begin
        #500000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: lanes done=%0d/%0d, required both 1",
                 g_lane[0].lane_done, g_lane[1].lane_done);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
